// File: rtl/uart_rx_deserializer.sv
// UART receive front end: synchronizes the serial line, detects the start bit on the
// oversampling tick, assembles DATA_BITS data bits LSB first and samples the stop bit.
module uart_rx_deserializer #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 baud_tick,
    input  logic                 rx_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 stop_bit_out,
    output logic                 chk_stop,
    output logic                 rx_busy,
    output logic                 start_error
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t                state_reg;
    logic                  rx_meta_reg;
    logic                  rx_s_reg;
    logic [TICK_W-1:0]     tick_cnt_reg;
    logic [BIT_W-1:0]      bit_cnt_reg;
    logic [DATA_BITS-1:0]  shift_reg;

    assign rx_busy = (state_reg != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta_reg  <= 1'b1;
            rx_s_reg     <= 1'b1;
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            data_out     <= '0;
            stop_bit_out <= 1'b1;
            chk_stop     <= 1'b0;
            start_error  <= 1'b0;
        end else begin
            // The synchronizer runs every clock; only the frame logic waits for baud_tick.
            rx_meta_reg <= rx_in;
            rx_s_reg    <= rx_meta_reg;
            chk_stop    <= 1'b0;
            start_error <= 1'b0;

            if (baud_tick) begin
                case (state_reg)
                    IDLE: begin
                        if (!rx_s_reg) begin
                            state_reg    <= START;
                            tick_cnt_reg <= '0;
                        end
                    end

                    START: begin
                        if (tick_cnt_reg == TICK_MID) begin
                            tick_cnt_reg <= '0;
                            if (!rx_s_reg) begin
                                state_reg   <= DATA;
                                bit_cnt_reg <= '0;
                            end else begin
                                state_reg   <= IDLE;
                                start_error <= 1'b1;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                        end
                    end

                    DATA: begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            tick_cnt_reg <= '0;
                            // Shift right so the first bit received ends up in the LSB.
                            shift_reg    <= {rx_s_reg, shift_reg[DATA_BITS-1:1]};
                            bit_cnt_reg  <= bit_cnt_reg + BIT_W'(1);
                            if (bit_cnt_reg == BIT_LAST) begin
                                state_reg <= STOP;
                            end
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                        end
                    end

                    STOP: begin
                        if (tick_cnt_reg == TICK_LAST) begin
                            // Returning to IDLE mid stop bit lets a back-to-back start edge be caught.
                            data_out     <= shift_reg;
                            stop_bit_out <= rx_s_reg;
                            chk_stop     <= 1'b1;
                            state_reg    <= IDLE;
                            tick_cnt_reg <= '0;
                        end else begin
                            tick_cnt_reg <= tick_cnt_reg + TICK_W'(1);
                        end
                    end

                    default: begin
                        state_reg <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Scoreboarded bench for uart_rx_deserializer: a default 8-bit/16x instance and a
// 7-bit/8x instance, driven with directed and random frames on a 4-clk baud tick.
module tb_uart_rx_deserializer;

    localparam int TICK_CLKS = 4;

    typedef struct {
        int         kind;   // 0 = completed frame, 1 = start_error
        logic [8:0] data;
        logic       stop;
        int         cyc;
    } exp_t;

    logic       clk;
    logic       rst;
    logic       baud_tick;
    logic       rx_a, rx_b;
    logic [7:0] data_a;
    logic [6:0] data_b;
    logic       stop_a, stop_b;
    logic       chk_a, chk_b;
    logic       busy_a, busy_b;
    logic       serr_a, serr_b;

    int         checks = 0;
    int         errors = 0;
    int         cyc    = 0;
    exp_t       q0[$];
    exp_t       q1[$];
    logic [8:0] last_data[2];

    uart_rx_deserializer #(.DATA_BITS(8), .OVERSAMPLE(16)) u_dut (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx_in        (rx_a),
        .data_out     (data_a),
        .stop_bit_out (stop_a),
        .chk_stop     (chk_a),
        .rx_busy      (busy_a),
        .start_error  (serr_a)
    );

    uart_rx_deserializer #(.DATA_BITS(7), .OVERSAMPLE(8)) u_dut7 (
        .clk          (clk),
        .rst          (rst),
        .baud_tick    (baud_tick),
        .rx_in        (rx_b),
        .data_out     (data_b),
        .stop_bit_out (stop_b),
        .chk_stop     (chk_b),
        .rx_busy      (busy_b),
        .start_error  (serr_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    initial begin
        int bcnt;
        bcnt      = 0;
        baud_tick = 1'b0;
        forever begin
            @(negedge clk);
            bcnt      = (bcnt + 1) % TICK_CLKS;
            baud_tick = (bcnt == 0);
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive(input int which, input logic b);
        if (which == 0) rx_a = b;
        else            rx_b = b;
    endtask

    // Waits n baud ticks, then returns on the following falling edge.
    task automatic wait_ticks(input int n);
        repeat (n) begin
            @(posedge clk);
            while (!baud_tick) @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic push(input int which, input exp_t e);
        if (which == 0) q0.push_back(e);
        else            q1.push_back(e);
    endtask

    task automatic push_serr(input int which);
        exp_t e;
        e.kind = 1;
        e.data = '0;
        e.stop = 1'b0;
        e.cyc  = 0;
        push(which, e);
    endtask

    task automatic idle(input int which, input int nbits);
        drive(which, 1'b1);
        wait_ticks(nbits * (which == 0 ? 16 : 8));
    endtask

    // Full frame: start bit, nb data bits LSB first, one stop bit; line is left at the stop level.
    task automatic send_frame(input int which, input int data, input logic stop);
        int         nb;
        int         os;
        logic [8:0] d;
        exp_t       e;
        nb = (which == 0) ? 8 : 7;
        os = (which == 0) ? 16 : 8;
        d  = 9'(data & ((1 << nb) - 1));
        drive(which, 1'b0);
        wait_ticks(1);
        if (which == 0) check("busy_at_start", busy_a, 1);
        e.kind = 0;
        e.data = d;
        e.stop = stop;
        e.cyc  = cyc + (os / 2 + nb * os + os) * TICK_CLKS;
        push(which, e);
        wait_ticks(os - 1);
        for (int i = 0; i < nb; i++) begin
            drive(which, d[i]);
            wait_ticks(os);
        end
        drive(which, stop);
        wait_ticks(os);
    endtask

    task automatic observe(input int which, input logic chk, input logic serr,
                           input logic busy, input logic stp, input logic [8:0] dat);
        exp_t e;
        int   qs;
        if (chk || serr) begin
            qs = (which == 0) ? q0.size() : q1.size();
            if (qs == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_strobe dut%0d: chk_stop=%0b start_error=%0b, expected none (cycle %0d)",
                         which, chk, serr, cyc);
            end else begin
                if (which == 0) e = q0.pop_front();
                else            e = q1.pop_front();
                if (chk) begin
                    $display("dut%0d frame: data=%0h stop=%0b at cycle %0d", which, dat, stp, cyc);
                    check("kind_frame", 32'(e.kind), 0);
                    check("data_out", dat, e.data);
                    check("stop_bit_out", stp, e.stop);
                    check("chk_latency", cyc, e.cyc);
                    check("busy_at_chk", busy, 0);
                    check("no_serr_with_chk", serr, 0);
                    last_data[which] = e.data;
                end else begin
                    $display("dut%0d start_error at cycle %0d", which, cyc);
                    check("kind_serr", 32'(e.kind), 1);
                    check("data_hold_serr", dat, last_data[which]);
                    check("busy_at_serr", busy, 0);
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        observe(0, chk_a, serr_a, busy_a, stop_a, {1'b0, data_a});
        observe(1, chk_b, serr_b, busy_b, stop_b, {2'b00, data_b});
    end

    initial begin
        int   d;
        logic s;
        rst          = 1'b1;
        rx_a         = 1'b1;
        rx_b         = 1'b1;
        last_data[0] = '0;
        last_data[1] = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_data", data_a, 0);
        check("rst_stop", stop_a, 1);
        check("rst_chk", chk_a, 0);
        check("rst_busy", busy_a, 0);
        check("rst_serr", serr_a, 0);
        check("rst_data7", data_b, 0);
        @(negedge clk);
        rst = 1'b0;
        idle(0, 1);

        send_frame(0, 'hA5, 1'b1);
        idle(0, 2);

        send_frame(0, 'h3C, 1'b0);
        check("busy_after_bad_stop", busy_a, 1);
        push_serr(0);
        idle(0, 2);

        drive(0, 1'b0);
        wait_ticks(3);
        push_serr(0);
        idle(0, 2);
        check("busy_after_glitch", busy_a, 0);

        send_frame(0, 'h01, 1'b1);
        send_frame(0, 'hFF, 1'b1);
        idle(0, 2);

        // Abort 0x55 partway through data bit 4.
        drive(0, 1'b0);
        wait_ticks(16);
        for (int i = 0; i < 4; i++) begin
            drive(0, (i % 2) == 0);
            wait_ticks(16);
        end
        drive(0, 1'b1);
        wait_ticks(8);
        rst  = 1'b1;
        rx_a = 1'b1;
        #1;
        check("midrst_data", data_a, 0);
        check("midrst_stop", stop_a, 1);
        check("midrst_busy", busy_a, 0);
        check("midrst_chk", chk_a, 0);
        check("midrst_serr", serr_a, 0);
        last_data[0] = '0;
        last_data[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        idle(0, 2);
        send_frame(0, 'h96, 1'b1);
        idle(0, 1);

        for (int n = 0; n < 16; n++) begin
            d = int'($urandom_range(0, 255));
            s = ($urandom_range(0, 3) != 0);
            send_frame(0, d, s);
            if (!s) begin
                push_serr(0);
                idle(0, int'($urandom_range(1, 3)));
            end else if ($urandom_range(0, 1) == 1) begin
                idle(0, int'($urandom_range(1, 2)));
            end
        end
        idle(0, 2);

        send_frame(1, 'h5A, 1'b1);
        idle(1, 2);
        for (int n = 0; n < 8; n++) begin
            d = int'($urandom_range(0, 127));
            s = ($urandom_range(0, 3) != 0);
            send_frame(1, d, s);
            if (!s) begin
                push_serr(1);
                idle(1, int'($urandom_range(1, 3)));
            end else if ($urandom_range(0, 1) == 1) begin
                idle(1, int'($urandom_range(1, 2)));
            end
        end
        idle(1, 3);

        check("q0_drained", q0.size(), 0);
        check("q1_drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/uart_rx_deserializer.md
Name: uart_rx_deserializer

Overview:
- Front end of the UART receive path. Samples the asynchronous serial line using an oversampling tick and detects the start bit.
- Shifts in DATA_BITS data bits, LSB first, and samples the stop bit.
- Presents the assembled byte, the sampled stop bit and a one-cycle check strobe to the downstream stop-bit checker. That checker flags a framing error and masks the data.

Parameters:
DATA_BITS, 8, number of data bits per frame (5..9 supported)
OVERSAMPLE, 16, baud_tick pulses per bit period (even, >=4)

Ports:
clk  input  1  system clock; all logic on rising edge
rst  input  1  asynchronous, active-high reset
baud_tick  input  1  one-clk pulse at OVERSAMPLE x baud rate; state advances only on cycles with baud_tick=1
rx_in  input  1  raw asynchronous serial line, idle high
data_out  output  DATA_BITS  last received data word; feeds checker data_in
stop_bit_out  output  1  sampled stop-bit level of last frame; feeds checker stop_bit_in
chk_stop  output  1  one-clk strobe: data_out/stop_bit_out updated and valid; feeds checker chk_stop
rx_busy  output  1  high while a frame is in progress (state != IDLE)
start_error  output  1  one-clk strobe: start bit rejected as a glitch

Behaviour:
- Synchronizer: rx_in passes through two flops (reset value 1) to give rx_s. All sampling uses rx_s. This adds 2 clk latency.
- Reset values: data_out=0, stop_bit_out=1, chk_stop=0, rx_busy=0, start_error=0, state=IDLE, tick_cnt=0, bit_cnt=0, shift register=0.
- Counters: tick_cnt has width clog2(OVERSAMPLE). bit_cnt has width clog2(DATA_BITS+1).
- Counter update rules: counters change only on baud_tick cycles. tick_cnt wraps to 0 at each sample point.
- States and transitions:
  - IDLE: on baud_tick with rx_s=0, go to START with tick_cnt=0. rx_s=1 stays in IDLE.
  - START: on each baud_tick, tick_cnt increments. When baud_tick and tick_cnt==OVERSAMPLE/2-1 (mid start bit):
    - rx_s=0: go to DATA, tick_cnt=0, bit_cnt=0.
    - rx_s=1: go to IDLE and pulse start_error for 1 clk.
  - DATA: on baud_tick with tick_cnt==OVERSAMPLE-1, sample rx_s into the shift register MSB and shift right (LSB-first assembly). Then tick_cnt=0, bit_cnt+1. When this sample is the DATA_BITS-th, go to STOP. Otherwise tick_cnt increments per baud_tick.
  - STOP: on baud_tick with tick_cnt==OVERSAMPLE-1, in the same edge:
    - data_out <= shift register;
    - stop_bit_out <= rx_s;
    - chk_stop <= 1;
    - go to IDLE, tick_cnt=0.
- chk_stop timing: high exactly the cycle after the stop sample edge, then 0. Asserted once per completed frame, regardless of stop level; error judgment belongs downstream.
- Output hold: data_out and stop_bit_out hold their values until the next frame completes. They do not change on false starts.
- rx_busy: combinational from state (state != IDLE). Low in the same cycle IDLE is re-entered.
- Back-to-back frames: IDLE after STOP is entered mid stop bit. A start edge on the following baud_tick is accepted, with no dead time.
- Stop bit low (framing error or break): frame still completes normally with stop_bit_out=0. The block then re-enters IDLE, sees rx_s=0 and begins a new START. If the line stays low, the START check passes and a garbage frame is received. This is accepted behaviour; the checker flags it.
- baud_tick low: all state and counters hold. rx_in changes between ticks are ignored.
- Reset mid-frame: asserting rst clears everything immediately (async). No chk_stop is issued for the aborted frame. After release, the block waits for a fresh low in IDLE.
- No simultaneous-strobe case: chk_stop and start_error are never high in the same cycle.

Test Plan:
- Common setup: OVERSAMPLE=16, DATA_BITS=8, baud_tick every 4 clk.
- Good frame: send 0xA5 with stop=1 -> one chk_stop pulse; data_out=0xA5, stop_bit_out=1, rx_busy high from start detect until the pulse. Required latency from start-edge tick to chk_stop: 8+8x16+16 ticks + 1 clk.
- Bad stop: send 0x3C with stop=0 -> chk_stop pulse, data_out=0x3C, stop_bit_out=0. Block re-enters START because the line is low.
- Glitch: drive rx_in low for 3 ticks then high -> start_error pulse of 1 clk, rx_busy returns to 0, no chk_stop, data_out unchanged.
- Back-to-back: 0x01 then 0xFF with one stop bit each and no idle gap -> two chk_stop pulses, data_out=0x01 then 0xFF, stop_bit_out=1 both times.
- Reset mid-frame: assert rst after 4 data bits of 0x55 -> all outputs return to reset values at once. A following frame 0x96 is received correctly.
- Parameter sweep: DATA_BITS=7, OVERSAMPLE=8, send 0x5A (7-bit) -> data_out=7'h5A, stop_bit_out=1, single chk_stop.
